lbist_wb_seq: RTL and testbench
===============================

LBIST_WB_SEQ -- requirements
Module: lbist_wb_seq

Interface
REQ-001 Parameter: POLL_GAP, default 16, idle cycles between status polls (>=1).
REQ-002 Parameter: MAX_POLLS, default 1024, status reads before timeout abort (>=1).
REQ-003 wb_clk  in  1  single clock for all logic.
REQ-004 wb_rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  one-cycle run request.
REQ-006 cfg_pat  in  16  scan pattern count to program.
REQ-007 cfg_chain_depth  in  16  scan chain depth to program.
REQ-008 cfg_rsb  in  1  reset-scan-compare bypass bit to program.
REQ-009 cfg_golden_sig  in  32  expected signature.
REQ-010 busy  out  1  sequence in progress.
REQ-011 done  out  1  one-cycle pulse at sequence end (pass, fail or error).
REQ-012 pass / fail  out  1 each  sticky result flags.
REQ-013 err  out  1  sticky bus-error/timeout flag.
REQ-014 sig_out  out  32  last signature read.
REQ-015 wbm_cs, wbm_wr  out  1 each; wbm_addr  out  2; wbm_wdata  out  32; wbm_be  out  4  register-bus master request.
REQ-016 wbm_rdata  in  32; wbm_ack  in  1; wbm_err  in  1  register-bus response from LBIST top.

Function
REQ-017 Target register map SHALL be: addr0 control {bit0 srst, bit1 start, bit2 rsb}; addr1 {[31:16] chain_depth, [15:0] pat}; addr2 status {bit0 done}; addr3 signature.
REQ-018 On start in IDLE, cfg_* SHALL be captured into internal registers; pass/fail/err/sig_out cleared; busy asserted next cycle.
REQ-019 start while busy SHALL be ignored.
REQ-020 FSM states: IDLE, WR_CFG, WR_SRST, WR_RUN, GAP, RD_STAT, RD_SIG, WR_CLR, FINISH.
REQ-021 Order: WR_CFG (addr1) -> WR_SRST (addr0=0x1) -> WR_RUN (addr0={rsb,1,0}) -> GAP -> RD_STAT -> RD_SIG -> WR_CLR (addr0=0x0) -> FINISH -> IDLE.
REQ-022 Each access SHALL assert wbm_cs with wbm_be=4'hF and hold addr/wr/wdata stable until wbm_ack or wbm_err sampled high.
REQ-023 wbm_cs SHALL deassert the cycle after ack/err; at least one cs-low cycle between accesses.
REQ-024 GAP SHALL count exactly POLL_GAP cycles with cs low, then enter RD_STAT.
REQ-025 RD_STAT ack with rdata[0]=1 -> RD_SIG; with rdata[0]=0 -> increment poll counter, back to GAP.
REQ-026 Poll counter reaching MAX_POLLS reads without done SHALL set err, skip RD_SIG, go to WR_CLR.
REQ-027 RD_SIG ack SHALL load sig_out=wbm_rdata; pass=(rdata==golden), fail=~pass, registered same edge.
REQ-028 wbm_err in any access SHALL set err, clear pass/fail, abort directly to FINISH (no WR_CLR).
REQ-029 FINISH SHALL pulse done for one cycle and deassert busy the same cycle; next state IDLE.
REQ-030 ack and err high together SHALL be treated as err.
REQ-031 ack/err while wbm_cs low SHALL be ignored.

Reset
REQ-032 wb_rst high SHALL asynchronously force IDLE; busy, done, pass, fail, err, wbm_cs, wbm_wr = 0; wbm_addr, wbm_wdata, sig_out, counters = 0; wbm_be = 0.
REQ-033 Reset mid-transaction SHALL drop wbm_cs immediately; no access resumes after release.
REQ-034 First start SHALL be accepted the first clock after reset deasserts.

Verification
REQ-035 pat=0x0010, depth=0x0020, rsb=1, done on 3rd poll, sig=golden=0xA5A5_1234 -> writes addr1=0x0020_0010, addr0=0x1, addr0=0x6, 3 addr2 reads, addr3 read, addr0=0x0; pass=1, done pulse.
REQ-036 Same run, sig=0xA5A5_1235 -> fail=1, pass=0, sig_out=0xA5A5_1235.
REQ-037 Status never done, MAX_POLLS=4 -> exactly 4 addr2 reads, no addr3 read, addr0=0x0 written, err=1.
REQ-038 wbm_err on WR_RUN -> err=1, no further cs, done pulse, busy=0.
REQ-039 Responder acks after 5 wait cycles, start pulsed during run -> signals stable 5 cycles, second start ignored, single done.
REQ-040 wb_rst asserted during RD_STAT -> cs=0 same cycle, all outputs zero, idle after release.

Source files
------------

// File: rtl/lbist_wb_seq.sv
// LBIST run sequencer: programs the LBIST top over a small register bus, polls
// for completion, reads the signature back and reports pass/fail/error.
module lbist_wb_seq #(
    parameter int POLL_GAP  = 16,
    parameter int MAX_POLLS = 1024
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic        start,
    input  logic [15:0] cfg_pat,
    input  logic [15:0] cfg_chain_depth,
    input  logic        cfg_rsb,
    input  logic [31:0] cfg_golden_sig,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        err,
    output logic [31:0] sig_out,
    output logic        wbm_cs,
    output logic        wbm_wr,
    output logic [1:0]  wbm_addr,
    output logic [31:0] wbm_wdata,
    output logic [3:0]  wbm_be,
    input  logic [31:0] wbm_rdata,
    input  logic        wbm_ack,
    input  logic        wbm_err
);

    localparam int GW = (POLL_GAP  > 1) ? $clog2(POLL_GAP)  : 1;
    localparam int PW = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS - 1);

    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_CFG  = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_SIG  = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_CFG,
        S_WR_SRST,
        S_WR_RUN,
        S_GAP,
        S_RD_STAT,
        S_RD_SIG,
        S_WR_CLR,
        S_FINISH
    } state_t;

    state_t         state;
    logic [15:0]    pat_q;
    logic [15:0]    depth_q;
    logic           rsb_q;
    logic [31:0]    golden_q;
    logic [GW-1:0]  gap_cnt;
    logic [PW-1:0]  poll_cnt;

    logic [1:0]     acc_addr;
    logic           acc_wr;
    logic [31:0]    acc_wdata;

    // Bus request implied by the current access state.
    always_comb begin
        acc_addr  = A_CTRL;
        acc_wr    = 1'b0;
        acc_wdata = 32'h0;
        case (state)
            S_WR_CFG: begin
                acc_addr  = A_CFG;
                acc_wr    = 1'b1;
                acc_wdata = {depth_q, pat_q};
            end
            S_WR_SRST: begin
                acc_addr  = A_CTRL;
                acc_wr    = 1'b1;
                acc_wdata = 32'h1;
            end
            S_WR_RUN: begin
                acc_addr  = A_CTRL;
                acc_wr    = 1'b1;
                acc_wdata = {29'h0, rsb_q, 2'b10};
            end
            S_RD_STAT: acc_addr = A_STAT;
            S_RD_SIG:  acc_addr = A_SIG;
            S_WR_CLR: begin
                acc_addr  = A_CTRL;
                acc_wr    = 1'b1;
                acc_wdata = 32'h0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state     <= S_IDLE;
            pat_q     <= '0;
            depth_q   <= '0;
            rsb_q     <= 1'b0;
            golden_q  <= '0;
            gap_cnt   <= '0;
            poll_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            err       <= 1'b0;
            sig_out   <= '0;
            wbm_cs    <= 1'b0;
            wbm_wr    <= 1'b0;
            wbm_addr  <= '0;
            wbm_wdata <= '0;
            wbm_be    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pat_q    <= cfg_pat;
                        depth_q  <= cfg_chain_depth;
                        rsb_q    <= cfg_rsb;
                        golden_q <= cfg_golden_sig;
                        pass     <= 1'b0;
                        fail     <= 1'b0;
                        err      <= 1'b0;
                        sig_out  <= '0;
                        poll_cnt <= '0;
                        gap_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= S_WR_CFG;
                    end
                end

                // The status read is issued straight out of the gap so the
                // cs-low interval between polls is exactly POLL_GAP cycles.
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt   <= '0;
                        wbm_cs    <= 1'b1;
                        wbm_be    <= 4'hF;
                        wbm_wr    <= 1'b0;
                        wbm_addr  <= A_STAT;
                        wbm_wdata <= 32'h0;
                        state     <= S_RD_STAT;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                S_FINISH: state <= S_IDLE;

                default: begin
                    if (!wbm_cs) begin
                        wbm_cs    <= 1'b1;
                        wbm_be    <= 4'hF;
                        wbm_wr    <= acc_wr;
                        wbm_addr  <= acc_addr;
                        wbm_wdata <= acc_wdata;
                    end else if (wbm_err) begin
                        // Error wins over a simultaneous ack; skip the clear write.
                        wbm_cs <= 1'b0;
                        wbm_be <= 4'h0;
                        err    <= 1'b1;
                        pass   <= 1'b0;
                        fail   <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_FINISH;
                    end else if (wbm_ack) begin
                        wbm_cs <= 1'b0;
                        wbm_be <= 4'h0;
                        case (state)
                            S_WR_CFG:  state <= S_WR_SRST;
                            S_WR_SRST: state <= S_WR_RUN;
                            S_WR_RUN: begin
                                gap_cnt <= '0;
                                state   <= S_GAP;
                            end
                            S_RD_STAT: begin
                                if (wbm_rdata[0]) begin
                                    state <= S_RD_SIG;
                                end else if (poll_cnt == POLL_LAST) begin
                                    err   <= 1'b1;
                                    state <= S_WR_CLR;
                                end else begin
                                    poll_cnt <= poll_cnt + 1'b1;
                                    gap_cnt  <= '0;
                                    state    <= S_GAP;
                                end
                            end
                            S_RD_SIG: begin
                                sig_out <= wbm_rdata;
                                pass    <= (wbm_rdata == golden_q);
                                fail    <= (wbm_rdata != golden_q);
                                state   <= S_WR_CLR;
                            end
                            S_WR_CLR: begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_FINISH;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbist_wb_seq.sv
// Directed bench for lbist_wb_seq with a behavioural register-bus responder.
module tb_lbist_wb_seq;

    logic        wb_clk, wb_rst, start;
    logic [15:0] cfg_pat, cfg_chain_depth;
    logic        cfg_rsb;
    logic [31:0] cfg_golden_sig;
    logic        busy, done, pass, fail, err;
    logic [31:0] sig_out;
    logic        wbm_cs, wbm_wr;
    logic [1:0]  wbm_addr;
    logic [31:0] wbm_wdata;
    logic [3:0]  wbm_be;
    logic [31:0] wbm_rdata;
    logic        wbm_ack, wbm_err;

    lbist_wb_seq #(.POLL_GAP(2), .MAX_POLLS(4)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start),
        .cfg_pat(cfg_pat), .cfg_chain_depth(cfg_chain_depth), .cfg_rsb(cfg_rsb),
        .cfg_golden_sig(cfg_golden_sig),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .err(err),
        .sig_out(sig_out),
        .wbm_cs(wbm_cs), .wbm_wr(wbm_wr), .wbm_addr(wbm_addr),
        .wbm_wdata(wbm_wdata), .wbm_be(wbm_be),
        .wbm_rdata(wbm_rdata), .wbm_ack(wbm_ack), .wbm_err(wbm_err)
    );

    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Responder knobs (written by the stimulus process only)
    int          wait_cycles = 0;
    int          done_on     = 3;
    logic [31:0] sig_val     = 32'h0;
    bit          inj_en      = 1'b0;

    // Access log and bookkeeping (written by the responder only)
    logic [1:0]  log_addr [256];
    logic        log_wr   [256];
    logic [31:0] log_wdata[256];
    int          log_n      = 0;
    int          stable_bad = 0;
    int          polls      = 0;
    int          done_cnt   = 0;

    always @(posedge wb_clk) if (done) done_cnt <= done_cnt + 1;

    initial begin : responder
        int          wcnt;
        logic [1:0]  c_addr;
        logic        c_wr;
        logic [31:0] c_wdata;
        wcnt = 0;
        wbm_ack = 1'b0; wbm_err = 1'b0; wbm_rdata = 32'h0;
        forever begin
            @(posedge wb_clk); #1;
            if (wbm_ack || wbm_err) begin
                wbm_ack = 1'b0; wbm_err = 1'b0; wcnt = 0;
            end else if (wbm_cs && !wb_rst) begin
                if (wcnt == 0) begin
                    c_addr = wbm_addr; c_wr = wbm_wr; c_wdata = wbm_wdata;
                end else if ({wbm_addr, wbm_wr, wbm_wdata} != {c_addr, c_wr, c_wdata}) begin
                    stable_bad++;
                end
                if (wbm_be != 4'hF) stable_bad++;
                if (wcnt < wait_cycles) begin
                    wcnt++;
                end else begin
                    wcnt = 0;
                    if (log_n < 256) begin
                        log_addr[log_n] = wbm_addr; log_wr[log_n] = wbm_wr;
                        log_wdata[log_n] = wbm_wdata;
                    end
                    log_n++;
                    if (inj_en && wbm_wr && wbm_addr == 2'd0 && wbm_wdata == 32'h6) begin
                        wbm_err = 1'b1;
                    end else begin
                        wbm_ack = 1'b1;
                        case (wbm_addr)
                            2'd1: begin polls = 0; wbm_rdata = 32'h0; end
                            2'd2: begin
                                polls++;
                                wbm_rdata = (done_on != 0 && polls >= done_on) ? 32'h1 : 32'h0;
                            end
                            2'd3: wbm_rdata = sig_val;
                            default: wbm_rdata = 32'h0;
                        endcase
                    end
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic chk_log(input string tag, input int idx, input logic [1:0] a,
                           input logic w, input logic [31:0] d);
        chk(tag, {log_addr[idx], log_wr[idx], log_wdata[idx]}, {a, w, d});
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(posedge wb_clk); #1;
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            chk({tag, "_busy_at_done"}, busy, 0);
            @(posedge wb_clk); #1;
            chk({tag, "_done_one_cycle"}, done, 0);
        end
    endtask

    // Pulse start for one cycle from the current (mid-cycle) time and wait for the end.
    task automatic run(input string tag);
        start = 1'b1;
        @(posedge wb_clk); #1;
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        wait_done(tag);
    endtask

    int base, d0;

    initial begin
        wb_rst = 1'b1; start = 1'b0;
        cfg_pat = 16'h0010; cfg_chain_depth = 16'h0020; cfg_rsb = 1'b1;
        cfg_golden_sig = 32'hA5A5_1234;
        #12;
        chk("rst_flags", {busy, done, pass, fail, err}, 0);
        chk("rst_bus", {wbm_cs, wbm_wr, wbm_addr, wbm_be}, 0);
        chk("rst_data", {wbm_wdata, sig_out}, 0);

        // Golden signature, done on third poll; start on first clock after reset
        done_on = 3; sig_val = 32'hA5A5_1234; wait_cycles = 0;
        base = log_n; d0 = done_cnt;
        @(negedge wb_clk); wb_rst = 1'b0;
        run("pass");
        chk("pass_nacc", log_n - base, 8);
        chk_log("pass_a0", base + 0, 2'd1, 1'b1, 32'h0020_0010);
        chk_log("pass_a1", base + 1, 2'd0, 1'b1, 32'h1);
        chk_log("pass_a2", base + 2, 2'd0, 1'b1, 32'h6);
        for (int i = 3; i < 6; i++) chk_log("pass_poll", base + i, 2'd2, 1'b0, 32'h0);
        chk_log("pass_sig", base + 6, 2'd3, 1'b0, 32'h0);
        chk_log("pass_clr", base + 7, 2'd0, 1'b1, 32'h0);
        chk("pass_flags", {pass, fail, err}, 3'b100);
        chk("pass_sig_out", sig_out, 32'hA5A5_1234);
        chk("pass_ndone", done_cnt - d0, 1);

        // Signature mismatch
        sig_val = 32'hA5A5_1235;
        base = log_n;
        @(negedge wb_clk);
        run("fail");
        chk("fail_nacc", log_n - base, 8);
        chk("fail_flags", {pass, fail, err}, 3'b010);
        chk("fail_sig_out", sig_out, 32'hA5A5_1235);

        // Status never done: MAX_POLLS=4 reads then clear write, no signature read
        done_on = 0;
        base = log_n;
        @(negedge wb_clk);
        run("tmo");
        chk("tmo_nacc", log_n - base, 8);
        for (int i = 3; i < 7; i++) chk_log("tmo_poll", base + i, 2'd2, 1'b0, 32'h0);
        chk_log("tmo_clr", base + 7, 2'd0, 1'b1, 32'h0);
        chk("tmo_flags", {pass, fail, err}, 3'b001);
        chk("tmo_sig_out", sig_out, 0);

        // Bus error on the run write aborts without the clear write
        done_on = 3; sig_val = 32'hA5A5_1234; inj_en = 1'b1;
        base = log_n;
        @(negedge wb_clk);
        run("berr");
        repeat (20) @(posedge wb_clk);
        #1;
        chk("berr_nacc", log_n - base, 3);
        chk("berr_flags", {pass, fail, err, busy, wbm_cs}, 5'b00100);
        inj_en = 1'b0;

        // Slow responder and a second start mid-run
        wait_cycles = 5;
        base = log_n; d0 = done_cnt;
        @(negedge wb_clk);
        start = 1'b1;
        @(posedge wb_clk); #1;
        start = 1'b0;
        chk("slow_busy", busy, 1);
        repeat (40) @(posedge wb_clk);
        #1;
        chk("slow_busy_mid", busy, 1);
        cfg_pat = 16'hFFFF; start = 1'b1;
        @(posedge wb_clk); #1;
        start = 1'b0; cfg_pat = 16'h0010;
        wait_done("slow");
        repeat (50) @(posedge wb_clk);
        #1;
        chk("slow_ndone", done_cnt - d0, 1);
        chk("slow_nacc", log_n - base, 8);
        chk_log("slow_cfg", base, 2'd1, 1'b1, 32'h0020_0010);
        chk("slow_flags", {pass, fail, err}, 3'b100);
        chk("slow_stable", stable_bad, 0);

        // Reset during a stalled status read
        done_on = 0;
        @(negedge wb_clk);
        start = 1'b1;
        @(posedge wb_clk); #1;
        start = 1'b0;
        begin
            bit hit;
            hit = 1'b0;
            for (int k = 0; k < 500 && !hit; k++) begin
                @(posedge wb_clk); #1;
                if (wbm_cs && wbm_addr == 2'd2) hit = 1'b1;
            end
            chk("rstmid_reach_stat", hit, 1);
        end
        #3 wb_rst = 1'b1;
        #1;
        chk("rstmid_cs", wbm_cs, 0);
        chk("rstmid_flags", {busy, done, pass, fail, err, wbm_wr, wbm_addr, wbm_be}, 0);
        chk("rstmid_data", {wbm_wdata, sig_out}, 0);
        repeat (2) @(posedge wb_clk);
        @(negedge wb_clk); wb_rst = 1'b0;
        base = log_n;
        repeat (30) @(posedge wb_clk);
        #1;
        chk("rstmid_idle", {busy, wbm_cs}, 0);
        chk("rstmid_nacc", log_n - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
